// File: rtl/or1200_vlx_pkg.sv
// Shared VLX extension definitions, imported by the load and store units.
package or1200_vlx_pkg;

   localparam int unsigned WORD_W = 32;
   localparam int unsigned BUF_W  = 64;
   localparam int unsigned PEEK_W = 16;

   typedef logic [6:0] fill_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RUN  = 2'd2
   } lu_state_e;

endpackage

// File: rtl/or1200_vlx_unstuff.sv
// JPEG byte unstuffing for one fetched word: drops each 0x00 that follows 0xFF,
// including across word boundaries, and left-justifies the surviving bytes.
module or1200_vlx_unstuff
   import or1200_vlx_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic [WORD_W-1:0] word_i,
   input  logic              valid_i,
   input  logic              clear_i,
   output logic [WORD_W-1:0] word_o,
   output fill_t             kept_o
);

   logic              prev_ff_q;
   logic [WORD_W-1:0] acc;
   logic [7:0]        byte_v;
   logic              prev;
   int unsigned       nkept;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i || clear_i)
         prev_ff_q <= 1'b0;
      else if (valid_i)
         prev_ff_q <= (word_i[7:0] == 8'hFF);
   end

   // Kept bytes are shifted in from the right, then the result is left-justified.
   always_comb begin
      acc    = '0;
      nkept  = 0;
      prev   = prev_ff_q;
      byte_v = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         byte_v = word_i[WORD_W-1-8*i -: 8];
         if (!(prev && byte_v == 8'h00)) begin
            acc   = {acc[WORD_W-9:0], byte_v};
            nkept = nkept + 1;
         end
         prev = (byte_v == 8'hFF);
      end
      word_o = acc << (8 * (4 - nkept));
      kept_o = fill_t'(8 * nkept);
   end

endmodule

// File: rtl/or1200_vlx_lu.sv
// VLX load unit: fetches big-endian words into a 64-bit bit buffer and presents
// 16 bits MSB-first to the decoder. Unstuffing enabled by OR1200_VLX_LU_UNSTUFF_EN.
module or1200_vlx_lu
   import or1200_vlx_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              set_init_addr_i,
   input  logic [WORD_W-1:0] dat_i,
   input  logic              ack_i,
   output logic              load_word_o,
   output logic [WORD_W-1:0] vlx_addr_o,
   input  logic              get_bits_i,
   input  logic [4:0]        nbits_i,
   output logic [PEEK_W-1:0] bits_o,
   output logic              bits_valid_o,
   output fill_t             fill_o
);

   lu_state_e         state_q, state_d;
   logic [BUF_W-1:0]  buf_q, buf_d, shifted;
   fill_t             fill_q, fill_d, fill_sh, n_eff;
   logic [WORD_W-1:0] addr_q, addr_d;
   logic [WORD_W-1:0] word_kept;
   fill_t             kept;
   logic              consume;
   logic              accept;

   assign accept = (state_q == REQ) && ack_i && !set_init_addr_i;

`ifdef OR1200_VLX_LU_UNSTUFF_EN
   or1200_vlx_unstuff u_unstuff (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .word_i  (dat_i),
      .valid_i (accept),
      .clear_i (set_init_addr_i),
      .word_o  (word_kept),
      .kept_o  (kept)
   );
`else
   assign word_kept = dat_i;
   assign kept      = fill_t'(WORD_W);
`endif

   // Consume is applied before the append so both can share one cycle.
   always_comb begin
      n_eff   = (nbits_i > 5'd16) ? fill_t'(PEEK_W) : {2'b00, nbits_i};
      consume = get_bits_i && (n_eff <= fill_q);
      shifted = consume ? (buf_q << n_eff) : buf_q;
      fill_sh = consume ? (fill_q - n_eff) : fill_q;

      state_d = state_q;
      buf_d   = shifted;
      fill_d  = fill_sh;
      addr_d  = addr_q;

      if (set_init_addr_i) begin
         state_d = RUN;
         buf_d   = '0;
         fill_d  = '0;
         addr_d  = {dat_i[WORD_W-1:2], 2'b00};
      end else begin
         case (state_q)
            RUN: begin
               if (fill_q <= fill_t'(WORD_W))
                  state_d = REQ;
            end
            REQ: begin
               if (accept) begin
                  state_d = RUN;
                  buf_d   = shifted | ({word_kept, {WORD_W{1'b0}}} >> fill_sh);
                  fill_d  = fill_sh + kept;
                  addr_d  = addr_q + 32'd4;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         buf_q   <= '0;
         fill_q  <= '0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         fill_q  <= fill_d;
         addr_q  <= addr_d;
      end
   end

   assign load_word_o  = (state_q == REQ);
   assign vlx_addr_o   = addr_q;
   assign bits_o       = buf_q[BUF_W-1 -: PEEK_W];
   assign bits_valid_o = (fill_q >= fill_t'(PEEK_W));
   assign fill_o       = fill_q;

endmodule
